// File: rtl/hsfir_pkg.sv
// Shared helpers for the systolic FIR: width arithmetic and saturation limits.
package hsfir_pkg;

  // Ceiling log2 for elaboration-time width sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Accumulator width: a full-precision product plus one bit per doubling of
  // the tap count, so the sum of NTAPS worst-case products can never wrap.
  function automatic int acc_width(input int iw, input int tw, input int ntaps);
    return iw + tw + clog2(ntaps);
  endfunction

  // Largest positive value representable in a signed ow-bit word (ow <= 63).
  function automatic longint sat_max(input int ow);
    return (longint'(1) <<< (ow - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a signed ow-bit word (ow <= 63).
  function automatic longint sat_min(input int ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

  // Limits for the default 16-bit output word, handy for quick reference.
  localparam int     DEF_OW      = 16;
  localparam longint DEF_SAT_MAX = sat_max(DEF_OW);
  localparam longint DEF_SAT_MIN = sat_min(DEF_OW);

endpackage

// File: rtl/hsfir_cell.sv
// One systolic FIR tap: coefficient register on a serial shift chain, two
// sample registers (the sample moves two stages per tap while the partial sum
// moves one, which lines up h[k] with x[n-k]), a product register and an
// accumulator register.
module hsfir_cell
  import hsfir_pkg::*;
#(
  parameter int IW = 16,
  parameter int TW = 16,
  parameter int AW = 35
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_tap_wr,
  input  logic signed [TW-1:0] i_tap,
  output logic signed [TW-1:0] o_tap,
  input  logic signed [IW-1:0] i_sample,
  output logic signed [IW-1:0] o_sample,
  input  logic signed [AW-1:0] i_acc,
  output logic signed [AW-1:0] o_acc
);

  localparam int PW = IW + TW;

  logic signed [TW-1:0] coef_q, coef_d;
  logic signed [IW-1:0] s1_q, s1_d;
  logic signed [IW-1:0] s2_q, s2_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc_q, acc_d;

  // Next-state: the coefficient shifts on i_tap_wr independently of i_ce;
  // everything on the data path moves only on i_ce. The product is formed
  // from coef_q, so a write in the same cycle does not affect it.
  always_comb begin
    coef_d = coef_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    if (i_tap_wr) begin
      coef_d = i_tap;
    end
    if (i_ce) begin
      s1_d   = i_sample;
      s2_d   = s1_q;
      prod_d = PW'(coef_q) * PW'(s1_q);
      acc_d  = i_acc + AW'(prod_q);
    end
  end

  // State registers, all cleared by the synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      coef_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      coef_q <= coef_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign o_tap    = coef_q;
  assign o_sample = s2_q;
  assign o_acc    = acc_q;

endmodule

// File: rtl/hsfir_systolic.sv
// Systolic FIR filter top: NTAPS chained MAC cells, serial coefficient load
// with a saturating load counter, and a round/saturate output register.
//
// Output handshake: o_valid is a one-cycle strobe, asserted the cycle after
// each i_ce seen while all coefficients are loaded; o_result/o_overflow are
// meaningful when o_valid is high and hold otherwise. There is no ready
// signal: the consumer must accept every strobe.
module hsfir_systolic
  import hsfir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int IW    = 16,
  parameter int TW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tap_wr,
  input  logic signed [TW-1:0] i_tap,
  output logic                 o_coef_ready,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_sample,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_result,
  output logic                 o_overflow
);

  // Derived widths; not overridable from outside.
  localparam int AW = acc_width(IW, TW, NTAPS);
  localparam int CW = clog2(NTAPS + 1);
  // Extended width for the rounding add and the range compare: wide enough
  // for y plus the rounding term and for the OW-bit limits, with headroom.
  localparam int EW = ((AW + 1 > OW) ? AW + 1 : OW) + 1;

  localparam logic [CW-1:0]        FULL_CNT = CW'(NTAPS);
  localparam logic signed [EW-1:0] RND      =
    (SHIFT > 0) ? (EW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [EW-1:0] SAT_HI   = EW'(sat_max(OW));
  localparam logic signed [EW-1:0] SAT_LO   = EW'(sat_min(OW));

  // Cell interconnect. Coefficients flow from the last cell toward cell 0,
  // samples and partial sums flow from cell 0 toward the last cell.
  logic signed [TW-1:0] tap_chain [NTAPS+1];
  logic signed [IW-1:0] smp_chain [NTAPS+1];
  logic signed [AW-1:0] acc_chain [NTAPS+1];

  assign tap_chain[NTAPS] = i_tap;
  assign smp_chain[0]     = i_sample;
  assign acc_chain[0]     = '0;

  for (genvar k = 0; k < NTAPS; k++) begin : g_cell
    hsfir_cell #(
      .IW (IW),
      .TW (TW),
      .AW (AW)
    ) u_cell (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_ce     (i_ce),
      .i_tap_wr (i_tap_wr),
      .i_tap    (tap_chain[k+1]),
      .o_tap    (tap_chain[k]),
      .i_sample (smp_chain[k]),
      .o_sample (smp_chain[k+1]),
      .i_acc    (acc_chain[k]),
      .o_acc    (acc_chain[k+1])
    );
  end

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 coef_ready;
  logic                 valid_q, valid_d;
  logic signed [OW-1:0] res_q, res_d;
  logic                 ovf_q, ovf_d;

  logic signed [EW-1:0] y_ext;
  logic signed [EW-1:0] rnd_sum;
  logic signed [EW-1:0] r_shift;
  logic signed [OW-1:0] sat_res;
  logic                 sat_flag;

  assign coef_ready = (cnt_q == FULL_CNT);

  // Load counter: counts tap writes and sticks at NTAPS so extra writes keep
  // o_coef_ready high.
  always_comb begin
    cnt_d = cnt_q;
    if (i_tap_wr && !coef_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Round half up by adding 2^(SHIFT-1) before the arithmetic shift, then
  // clamp to the signed OW-bit range and flag when clamping happened.
  always_comb begin
    y_ext    = EW'(acc_chain[NTAPS]);
    rnd_sum  = y_ext + RND;
    r_shift  = rnd_sum >>> SHIFT;
    sat_res  = r_shift[OW-1:0];
    sat_flag = 1'b0;
    if (r_shift > SAT_HI) begin
      sat_res  = SAT_HI[OW-1:0];
      sat_flag = 1'b1;
    end else if (r_shift < SAT_LO) begin
      sat_res  = SAT_LO[OW-1:0];
      sat_flag = 1'b1;
    end
  end

  // Output register: updates only on i_ce, and stays at zero until the
  // coefficient chain is fully loaded.
  always_comb begin
    valid_d = i_ce & coef_ready;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (i_ce) begin
      if (coef_ready) begin
        res_d = sat_res;
        ovf_d = sat_flag;
      end else begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    end
  end

  // Counter and output state registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_coef_ready = coef_ready;
  assign o_valid      = valid_q;
  assign o_result     = res_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_hsfir_systolic.sv
// Testbench for hsfir_systolic: three instances share one stimulus stream
// (defaults; SHIFT=0/OW=40; SHIFT=1/OW=16) and are compared with a
// sum-of-products reference model, plus vector tables for impulse/rounding.
module tb_hsfir_systolic;

  localparam int N    = 8;
  localparam int LAT  = N + 2;
  localparam int EXPW = 1 + 16 + 1 + 40 + 1 + 16;

  typedef logic signed [63:0] v64_t;
  typedef struct {
    longint x;
    longint exp;
  } vec_t;

  // ---------------- clock / reset / DUTs ----------------
  logic               clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_tap_wr = 1'b0;
  logic signed [15:0] i_tap = '0;
  logic               i_ce = 1'b0;
  logic signed [15:0] i_sample = '0;

  logic               rdy_a, rdy_b, rdy_c;
  logic               val_a, val_b, val_c;
  logic               ovf_a, ovf_b, ovf_c;
  logic signed [15:0] res_a;
  logic signed [39:0] res_b;
  logic signed [15:0] res_c;

  always #5 clk = ~clk;

  hsfir_systolic dut_a (
    .i_clk(clk), .i_reset(i_reset), .i_tap_wr(i_tap_wr), .i_tap(i_tap),
    .o_coef_ready(rdy_a), .i_ce(i_ce), .i_sample(i_sample),
    .o_valid(val_a), .o_result(res_a), .o_overflow(ovf_a)
  );

  hsfir_systolic #(.OW(40), .SHIFT(0)) dut_b (
    .i_clk(clk), .i_reset(i_reset), .i_tap_wr(i_tap_wr), .i_tap(i_tap),
    .o_coef_ready(rdy_b), .i_ce(i_ce), .i_sample(i_sample),
    .o_valid(val_b), .o_result(res_b), .o_overflow(ovf_b)
  );

  hsfir_systolic #(.SHIFT(1)) dut_c (
    .i_clk(clk), .i_reset(i_reset), .i_tap_wr(i_tap_wr), .i_tap(i_tap),
    .o_coef_ready(rdy_c), .i_ce(i_ce), .i_sample(i_sample),
    .o_valid(val_c), .o_result(res_c), .o_overflow(ovf_c)
  );

  // ---------------- reference model state ----------------
  longint             h [N];
  int                 cnt;
  longint             xs [$];
  logic [EXPW-1:0]    exp_q [$];
  longint             got_b [$];
  longint             got_c [$];
  logic               cur_oa, cur_ob, cur_oc;
  logic signed [15:0] cur_ra;
  logic signed [39:0] cur_rb;
  logic signed [15:0] cur_rc;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input v64_t act, input v64_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Round half up, shift, clamp: straight from the output-stage rules.
  function automatic void ref_out(input longint y, input int sh, input int ow,
                                  output longint res, output logic ovf);
    longint r, hi, lo;
    r   = (sh > 0) ? ((y + (longint'(1) <<< (sh - 1))) >>> sh) : y;
    hi  = (longint'(1) <<< (ow - 1)) - 1;
    lo  = -hi - 1;
    ovf = 1'b0;
    res = r;
    if (r > hi) begin res = hi; ovf = 1'b1; end
    else if (r < lo) begin res = lo; ovf = 1'b1; end
  endfunction

  // Expected outputs for the enable just taken: y[m] with m = n - (N+2),
  // y[m] = sum_k h[k] * x[m-k], samples before reset counting as zero.
  function automatic logic [EXPW-1:0] expected_entry();
    longint y, ra, rb, rc;
    logic   oa, ob, oc;
    int     m;
    m = xs.size() - 1 - LAT;
    y = 0;
    for (int k = 0; k < N; k++) begin
      if (m - k >= 0) y += h[k] * xs[m-k];
    end
    ref_out(y, 15, 16, ra, oa);
    ref_out(y, 0, 40, rb, ob);
    ref_out(y, 1, 16, rc, oc);
    return {oa, 16'(ra), ob, 40'(rb), oc, 16'(rc)};
  endfunction

  task automatic check_outputs(input logic exp_valid);
    logic exp_rdy;
    exp_rdy = (cnt == N);
    chk("coef_ready_a", v64_t'(rdy_a), v64_t'(exp_rdy));
    chk("coef_ready_b", v64_t'(rdy_b), v64_t'(exp_rdy));
    chk("coef_ready_c", v64_t'(rdy_c), v64_t'(exp_rdy));
    chk("valid_a", v64_t'(val_a), v64_t'(exp_valid));
    chk("valid_b", v64_t'(val_b), v64_t'(exp_valid));
    chk("valid_c", v64_t'(val_c), v64_t'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_nonempty", 64'sd0, 64'sd1);
      end else begin
        {cur_oa, cur_ra, cur_ob, cur_rb, cur_oc, cur_rc} = exp_q.pop_front();
      end
    end
    chk("result_a", v64_t'(res_a), v64_t'(cur_ra));
    chk("result_b", v64_t'(res_b), v64_t'(cur_rb));
    chk("result_c", v64_t'(res_c), v64_t'(cur_rc));
    chk("overflow_a", v64_t'(ovf_a), v64_t'(cur_oa));
    chk("overflow_b", v64_t'(ovf_b), v64_t'(cur_ob));
    chk("overflow_c", v64_t'(ovf_c), v64_t'(cur_oc));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic ce, input longint x, input logic wr, input longint tap);
    logic rdy_pre;
    i_ce     = ce;
    i_sample = 16'(x);
    i_tap_wr = wr;
    i_tap    = 16'(tap);
    rdy_pre  = (cnt == N);
    @(posedge clk);
    if (ce) begin
      xs.push_back(x);
      if (rdy_pre) exp_q.push_back(expected_entry());
    end
    if (wr) begin
      for (int k = 0; k < N - 1; k++) h[k] = h[k+1];
      h[N-1] = tap;
      if (cnt < N) cnt++;
    end
    #1;
    i_ce     = 1'b0;
    i_tap_wr = 1'b0;
    if (val_b) got_b.push_back(longint'(res_b));
    if (val_c) got_c.push_back(longint'(res_c));
    check_outputs(ce && rdy_pre);
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_tap_wr = 1'b0;
    i_sample = '0;
    i_tap    = '0;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    for (int k = 0; k < N; k++) h[k] = 0;
    cnt = 0;
    xs.delete();
    exp_q.delete();
    got_b.delete();
    got_c.delete();
    cur_oa = 0; cur_ob = 0; cur_oc = 0;
    cur_ra = 0; cur_rb = 0; cur_rc = 0;
    chk("rst_valid_a", v64_t'(val_a), 64'sd0);
    chk("rst_result_a", v64_t'(res_a), 64'sd0);
    chk("rst_overflow_a", v64_t'(ovf_a), 64'sd0);
    chk("rst_ready_a", v64_t'(rdy_a), 64'sd0);
    chk("rst_result_b", v64_t'(res_b), 64'sd0);
    chk("rst_ready_b", v64_t'(rdy_b), 64'sd0);
    chk("rst_result_c", v64_t'(res_c), 64'sd0);
    chk("rst_ready_c", v64_t'(rdy_c), 64'sd0);
  endtask

  task automatic load(input longint hv [N]);
    for (int k = 0; k < N; k++) step(1'b0, 0, 1'b1, hv[k]);
  endtask

  // Apply a vector table with i_ce every cycle and compare the captured
  // valid outputs of instance B (use_c=0) or C (use_c=1) against it.
  task automatic run_table(input string nm, input vec_t tab [20], input logic use_c);
    got_b.delete();
    got_c.delete();
    for (int t = 0; t < 20; t++) step(1'b1, tab[t].x, 1'b0, 0);
    chk({nm, "_count"}, use_c ? got_c.size() : got_b.size(), 20);
    for (int t = 0; t < 20; t++) begin
      if ((use_c ? got_c.size() : got_b.size()) > t)
        chk($sformatf("%s_%0d", nm, t), use_c ? got_c[t] : got_b[t], tab[t].exp);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t   imp_tab [20];
  vec_t   rnd_tab [20];
  longint h_ramp [N];
  longint h_unit [N];
  longint h_max  [N];
  longint h_rand [N];

  initial begin
    // Impulse: h=1..8 at SHIFT=0 gives 1..8 on enables 10..17.
    for (int t = 0; t < 20; t++) begin
      imp_tab[t].x   = (t == 0) ? 1 : 0;
      imp_tab[t].exp = (t >= LAT && t < LAT + N) ? longint'(t - LAT + 1) : 0;
    end
    // Rounding at SHIFT=1 with h[0]=1: 3 -> 2, -3 -> -1, 2 -> 1.
    for (int t = 0; t < 20; t++) begin
      rnd_tab[t].x   = 0;
      rnd_tab[t].exp = 0;
    end
    rnd_tab[0].x = 3;  rnd_tab[LAT].exp   = 2;
    rnd_tab[1].x = -3; rnd_tab[LAT+1].exp = -1;
    rnd_tab[2].x = 2;  rnd_tab[LAT+2].exp = 1;
    for (int k = 0; k < N; k++) begin
      h_ramp[k] = k + 1;
      h_unit[k] = (k == 0) ? 1 : 0;
      h_max[k]  = 32767;
    end

    // Reset state
    do_reset();

    // Impulse response
    load(h_ramp);
    run_table("impulse", imp_tab, 1'b0);

    // Rounding
    do_reset();
    load(h_unit);
    run_table("rounding", rnd_tab, 1'b1);

    // Saturation, both directions
    do_reset();
    load(h_max);
    for (int t = 0; t < 20; t++) step(1'b1, 32767, 1'b0, 0);
    chk("sat_pos_result", v64_t'(res_a), 64'sd32767);
    chk("sat_pos_ovf", v64_t'(ovf_a), 64'sd1);
    for (int t = 0; t < 20; t++) step(1'b1, -32768, 1'b0, 0);
    chk("sat_neg_result", v64_t'(res_a), -64'sd32768);
    chk("sat_neg_ovf", v64_t'(ovf_a), 64'sd1);

    // Partial load while samples stream, writes coinciding with i_ce
    do_reset();
    for (int k = 0; k < N - 1; k++) step(1'b1, 100 + k, 1'b1, k + 1);
    chk("partial_ready7", v64_t'(rdy_a), 64'sd0);
    chk("partial_valid7", v64_t'(val_a), 64'sd0);
    step(1'b1, 5, 1'b1, N);
    chk("partial_ready8", v64_t'(rdy_a), 64'sd1);

    // Enable gaps: i_ce every third cycle; model checks hold and strobes
    do_reset();
    load(h_ramp);
    got_b.delete();
    for (int c = 0; c < 60; c++) step((c % 3) == 0, (c == 0) ? 1 : 0, 1'b0, 0);
    chk("gap_count", got_b.size(), 20);
    for (int t = 0; t < 20; t++) begin
      if (got_b.size() > t) chk($sformatf("gap_%0d", t), got_b[t], imp_tab[t].exp);
    end

    // Reset in the middle of the impulse output, then reload and retry
    do_reset();
    load(h_ramp);
    for (int t = 0; t < LAT + 3; t++) step(1'b1, (t == 0) ? 1 : 0, 1'b0, 0);
    do_reset();
    load(h_ramp);
    run_table("impulse_after_reset", imp_tab, 1'b0);

    // Randomized stream against the model
    do_reset();
    for (int k = 0; k < N; k++) begin
      logic signed [15:0] r16;
      r16 = 16'($urandom);
      h_rand[k] = r16;
    end
    load(h_rand);
    for (int t = 0; t < 400; t++) begin
      logic signed [15:0] xr;
      logic               ce;
      xr = 16'($urandom);
      if ($urandom_range(0, 7) == 0) xr = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
      ce = ($urandom_range(0, 3) != 0);
      step(ce, xr, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
